alu_operand_stage: RTL and testbench

//  Pipeline stage directly upstream of the 16-bit ALU. It accepts decoded instructions over a

---
 rtl/alu_operand_stage.sv | 146 ++++++++++++++
 tb/tb_alu_operand_stage.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : alu_operand_stage
// Description : Operand-build stage in front of the 16-bit combinational ALU.
//               Accepts decoded instructions over valid/ready and selects
//               operand A from rs_val or the previous ALU result. Operand B
//               comes from rt_val, the extended immediate, or the previous
//               ALU result. A, B and op are presented from registers, and a
//               2-entry (output + skid) buffer keeps full throughput under
//               backpressure.
// Ports       : clk, rst_n            clock, async active-low reset
//               in_valid/in_ready     upstream handshake
//               in_op, rs_val, rt_val, imm, use_imm, imm_sext, fwd_a, fwd_b
//                                     decoded instruction fields
//               out_valid/out_ready   downstream handshake
//               A, B, op              operands and opcode to the ALU
//               alu_r                 ALU result (combinational from A/B/op)
// Revision    : 1.0  initial release
// ============================================================================
module alu_operand_stage #(
    parameter int WIDTH     = 16,
    parameter int IMM_WIDTH = 8,
    parameter int OP_WIDTH  = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_op,
    input  logic [WIDTH-1:0]     rs_val,
    input  logic [WIDTH-1:0]     rt_val,
    input  logic [IMM_WIDTH-1:0] imm,
    input  logic                 use_imm,
    input  logic                 imm_sext,
    input  logic                 fwd_a,
    input  logic                 fwd_b,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic [OP_WIDTH-1:0]  op,
    input  logic [WIDTH-1:0]     alu_r
);

    // Output entry
    logic                r_out_valid;
    logic [OP_WIDTH-1:0] r_out_op;
    logic [WIDTH-1:0]    r_out_a;
    logic [WIDTH-1:0]    r_out_b;
    logic                r_out_fa;
    logic                r_out_fb;

    // Skid entry
    logic                r_skid_valid;
    logic [OP_WIDTH-1:0] r_skid_op;
    logic [WIDTH-1:0]    r_skid_a;
    logic [WIDTH-1:0]    r_skid_b;
    logic                r_skid_fa;
    logic                r_skid_fb;

    // Result of the most recent output handshake
    logic [WIDTH-1:0]    r_last_result;

    logic [WIDTH-1:0]    w_imm_ext;
    logic [WIDTH-1:0]    w_b_raw;
    logic                w_fb_eff;
    logic                w_accept;
    logic                w_drain;
    logic                w_out_free;

    assign w_imm_ext = imm_sext ? {{(WIDTH-IMM_WIDTH){imm[IMM_WIDTH-1]}}, imm}
                                : {{(WIDTH-IMM_WIDTH){1'b0}}, imm};
    // The immediate is folded into b_raw at capture time, so forwarding of B
    // only has to be suppressed here and never reconsidered downstream.
    assign w_b_raw    = use_imm ? w_imm_ext : rt_val;
    assign w_fb_eff   = fwd_b & ~use_imm;

    // Ready depends only on skid occupancy, so there is no combinational
    // path from out_ready back to in_ready.
    assign in_ready   = ~r_skid_valid;
    assign w_accept   = in_valid & ~r_skid_valid;
    assign w_drain    = r_out_valid & out_ready;
    assign w_out_free = ~r_out_valid | out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid   <= 1'b0;
            r_out_op      <= '0;
            r_out_a       <= '0;
            r_out_b       <= '0;
            r_out_fa      <= 1'b0;
            r_out_fb      <= 1'b0;
            r_skid_valid  <= 1'b0;
            r_skid_op     <= '0;
            r_skid_a      <= '0;
            r_skid_b      <= '0;
            r_skid_fa     <= 1'b0;
            r_skid_fb     <= 1'b0;
            r_last_result <= '0;
        end else begin
            if (w_drain) begin
                r_last_result <= alu_r;
            end

            if (w_out_free) begin
                if (r_skid_valid) begin
                    // in_ready is low while the skid is occupied, so no new
                    // input can arrive in the same cycle the skid moves up.
                    r_out_valid  <= 1'b1;
                    r_out_op     <= r_skid_op;
                    r_out_a      <= r_skid_a;
                    r_out_b      <= r_skid_b;
                    r_out_fa     <= r_skid_fa;
                    r_out_fb     <= r_skid_fb;
                    r_skid_valid <= 1'b0;
                end else if (w_accept) begin
                    r_out_valid  <= 1'b1;
                    r_out_op     <= in_op;
                    r_out_a      <= rs_val;
                    r_out_b      <= w_b_raw;
                    r_out_fa     <= fwd_a;
                    r_out_fb     <= w_fb_eff;
                end else begin
                    // Fields are kept so A/B/op hold while idle.
                    r_out_valid  <= 1'b0;
                end
            end else if (w_accept) begin
                r_skid_valid <= 1'b1;
                r_skid_op    <= in_op;
                r_skid_a     <= rs_val;
                r_skid_b     <= w_b_raw;
                r_skid_fa    <= fwd_a;
                r_skid_fb    <= w_fb_eff;
            end
        end
    end

    // Forwarding is resolved at the output. The predecessor of the output
    // entry has always handshaken already, so last_result is its result.
    assign A         = r_out_fa ? r_last_result : r_out_a;
    assign B         = r_out_fb ? r_last_result : r_out_b;
    assign op        = r_out_op;
    assign out_valid = r_out_valid;

endmodule
`default_nettype wire

// File: tb/tb_alu_operand_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_operand_stage
// Description : Self-checking bench for alu_operand_stage. A reference ALU
//               closes the forwarding loop. Accepted entries are queued and
//               compared in order as they leave the stage.
// Revision    : 1.0  initial release
// ============================================================================
module tb_alu_operand_stage;

    typedef struct packed {
        logic [2:0]  op;
        logic [15:0] a;
        logic [15:0] b;
        logic        fa;
        logic        fb;
    } entry_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [15:0] rs_val = '0;
    logic [15:0] rt_val = '0;
    logic [7:0]  imm = '0;
    logic        use_imm = 1'b0;
    logic        imm_sext = 1'b0;
    logic        fwd_a = 1'b0;
    logic        fwd_b = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] A;
    logic [15:0] B;
    logic [2:0]  op;
    logic [15:0] alu_r;

    int          vectors = 0;
    int          miscompares = 0;
    int          out_count = 0;
    bit          rand_mode = 1'b0;
    entry_t      sb[$];
    logic [15:0] a_log[$];
    logic [15:0] model_last = '0;
    entry_t      mon_e;
    logic [15:0] mon_ea;
    logic [15:0] mon_eb;

    always #5 clk = ~clk;

    function automatic logic [15:0] alu_f(input logic [15:0] a, input logic [15:0] b,
                                          input logic [2:0] o);
        case (o)
            3'd0:    alu_f = a & b;
            3'd1:    alu_f = a | b;
            3'd2:    alu_f = a + b;
            3'd3:    alu_f = a - b;
            3'd4:    alu_f = a ^ b;
            3'd5:    alu_f = a << b[3:0];
            3'd6:    alu_f = a >> b[3:0];
            default: alu_f = b;
        endcase
    endfunction

    assign alu_r = alu_f(A, B, op);

    alu_operand_stage #(.WIDTH(16), .IMM_WIDTH(8), .OP_WIDTH(3)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
        .rs_val(rs_val), .rt_val(rt_val), .imm(imm),
        .use_imm(use_imm), .imm_sext(imm_sext), .fwd_a(fwd_a), .fwd_b(fwd_b),
        .out_valid(out_valid), .out_ready(out_ready),
        .A(A), .B(B), .op(op), .alu_r(alu_r)
    );

    // Scoreboard: every output handshake pops the oldest accepted entry.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            out_count++;
            a_log.push_back(A);
            if (sb.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL sb_unexpected_output: got A=%h B=%h op=%0d, expected no output", A, B, op);
            end else begin
                mon_e  = sb.pop_front();
                mon_ea = mon_e.fa ? model_last : mon_e.a;
                mon_eb = mon_e.fb ? model_last : mon_e.b;
                vectors += 3;
                if (A !== mon_ea) begin
                    miscompares++;
                    $display("FAIL sb_A: got %h expected %h", A, mon_ea);
                end
                if (B !== mon_eb) begin
                    miscompares++;
                    $display("FAIL sb_B: got %h expected %h", B, mon_eb);
                end
                if (op !== mon_e.op) begin
                    miscompares++;
                    $display("FAIL sb_op: got %0d expected %0d", op, mon_e.op);
                end
                model_last = alu_f(mon_ea, mon_eb, mon_e.op);
            end
        end
    end

    // Random backpressure, changed just after each rising edge.
    always @(posedge clk) begin
        if (rand_mode) begin
            #1;
            out_ready = 1'($urandom_range(0, 1));
        end
    end

    // Called and returns at posedge+1; leaves in_valid low after acceptance.
    task automatic send(input logic [2:0] o, input logic [15:0] rs, input logic [15:0] rt,
                        input logic [7:0] im, input logic ui, input logic se,
                        input logic fa, input logic fb);
        entry_t e;
        logic [15:0] ext;
        in_valid = 1'b1; in_op = o; rs_val = rs; rt_val = rt; imm = im;
        use_imm = ui; imm_sext = se; fwd_a = fa; fwd_b = fb;
        ext = se ? {{8{im[7]}}, im} : {8'h00, im};
        e.op = o; e.a = rs; e.b = ui ? ext : rt; e.fa = fa; e.fb = fb & ~ui;
        for (int t = 0; t < 50; t++) begin
            @(negedge clk);
            if (in_ready) begin
                sb.push_back(e);
                @(posedge clk); #1;
                in_valid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        vectors++;
        miscompares++;
        $display("FAIL send_timeout: in_ready got 0, expected 1 within 50 cycles");
        in_valid = 1'b0;
    endtask

    task automatic drain_and_check(input string name);
        out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        vectors += 2;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL %s_drain: got %0d pending entries, expected 0", name, sb.size());
        end
        if (out_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_idle: got out_valid=%b expected 0", name, out_valid);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        #1;
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL rst_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL rst_in_ready: got %b expected 1", in_ready); end
        if (A !== 16'h0000)     begin miscompares++; $display("FAIL rst_A: got %h expected 0000", A); end
        if (B !== 16'h0000)     begin miscompares++; $display("FAIL rst_B: got %h expected 0000", B); end
        if (op !== 3'd0)        begin miscompares++; $display("FAIL rst_op: got %0d expected 0", op); end
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Fill both entries, then reset mid-run.
        out_ready = 1'b0;
        send(3'd1, 16'h00F0, 16'h000F, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3'd2, 16'h0101, 16'h0202, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        vectors++;
        if (in_ready !== 1'b0) begin miscompares++; $display("FAIL full_in_ready: got %b expected 0", in_ready); end
        rst_n = 1'b0;
        #1;
        sb.delete();
        model_last = '0;
        vectors += 5;
        if (out_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_out_valid: got %b expected 0", out_valid); end
        if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL midrst_in_ready: got %b expected 1", in_ready); end
        if (A !== 16'h0000)     begin miscompares++; $display("FAIL midrst_A: got %h expected 0000", A); end
        if (B !== 16'h0000)     begin miscompares++; $display("FAIL midrst_B: got %h expected 0000", B); end
        if (op !== 3'd0)        begin miscompares++; $display("FAIL midrst_op: got %0d expected 0", op); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(posedge clk); #1;

        // Forwarded entry straight after reset sees last_result = 0.
        out_ready = 1'b1;
        send(3'd2, 16'h1234, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        vectors++;
        if (A !== 16'h0000) begin miscompares++; $display("FAIL rst_fwd_A: got %h expected 0000", A); end
        @(posedge clk); #1;
        drain_and_check("reset");
    endtask

    task automatic test_back_to_back;
        out_ready = 1'b1;
        send(3'd2, 16'h0003, 16'h0005, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        @(negedge clk);
        vectors += 4;
        if (out_valid !== 1'b1) begin miscompares++; $display("FAIL add_out_valid: got %b expected 1", out_valid); end
        if (A !== 16'h0003)     begin miscompares++; $display("FAIL add_A: got %h expected 0003", A); end
        if (B !== 16'h0005)     begin miscompares++; $display("FAIL add_B: got %h expected 0005", B); end
        if (op !== 3'd2)        begin miscompares++; $display("FAIL add_op: got %0d expected 2", op); end
        @(posedge clk); #1;
        drain_and_check("add");

        send(3'd2, 16'h0003, 16'h0005, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3'd3, 16'h1111, 16'h0002, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        vectors += 3;
        if (A !== 16'h0008)     begin miscompares++; $display("FAIL b2b_A: got %h expected 0008", A); end
        if (B !== 16'h0002)     begin miscompares++; $display("FAIL b2b_B: got %h expected 0002", B); end
        if (op !== 3'd3)        begin miscompares++; $display("FAIL b2b_op: got %0d expected 3", op); end
        @(posedge clk); #1;
        drain_and_check("b2b");
    endtask

    task automatic test_imm_ext;
        logic [15:0] exp_b[2];
        exp_b[0] = 16'hFFFE;
        exp_b[1] = 16'h00FE;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            send(3'd5, 16'h0040, 16'h7777, 8'hFE, 1'b1, (k == 0), 1'b0, 1'b1);
            @(negedge clk);
            vectors++;
            if (B !== exp_b[k]) begin
                miscompares++;
                $display("FAIL imm_B sext=%0d: got %h expected %h", (k == 0), B, exp_b[k]);
            end
            @(posedge clk); #1;
        end
        drain_and_check("imm");
    endtask

    task automatic test_stall_fifo;
        int base;
        base = out_count;
        out_ready = 1'b0;
        send(3'd4, 16'h0A01, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        send(3'd4, 16'h0A02, 16'h0002, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        in_valid = 1'b1; in_op = 3'd4; rs_val = 16'h0A03; rt_val = 16'h0003;
        use_imm = 1'b0; fwd_a = 1'b0; fwd_b = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors += 3;
            if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL stall_in_ready c=%0d: got %b expected 0", c, in_ready); end
            if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_out_valid c=%0d: got %b expected 1", c, out_valid); end
            if (A !== 16'h0A01)     begin miscompares++; $display("FAIL stall_A c=%0d: got %h expected 0a01", c, A); end
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        send(3'd4, 16'h0A03, 16'h0003, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        drain_and_check("stall");
        vectors++;
        if (out_count - base != 3) begin
            miscompares++;
            $display("FAIL stall_count: got %0d outputs expected 3", out_count - base);
        end
    endtask

    task automatic test_fwd_chain_random;
        logic [15:0] exp_a[4];
        exp_a[0] = 16'h0001; exp_a[1] = 16'h0002; exp_a[2] = 16'h0003; exp_a[3] = 16'h0004;
        a_log.delete();
        rand_mode = 1'b1;
        send(3'd2, 16'h0001, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 4; k++) begin
            send(3'd2, 16'hBEEF, 16'h0001, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        end
        rand_mode = 1'b0;
        @(posedge clk); #2;
        drain_and_check("chain");
        vectors++;
        if (a_log.size() != 4) begin
            miscompares++;
            $display("FAIL chain_len: got %0d outputs expected 4", a_log.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                vectors++;
                if (a_log[k] !== exp_a[k]) begin
                    miscompares++;
                    $display("FAIL chain_A[%0d]: got %h expected %h", k, a_log[k], exp_a[k]);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_back_to_back();
        test_imm_ext();
        test_stall_fifo();
        test_fwd_chain_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
